// File: rtl/booth_pkg.sv
// Shared types for the Booth stage-chain arbiter: FSM state enums, default data width
// and the requester-id width helper.
package booth_pkg;

  localparam int BOOTH_DW = 64;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_RH   = 2'd1,
    I_RL   = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_HOLD = 2'd1,
    O_ACK  = 2'd2
  } out_state_t;

  // A single requester still needs a one-bit id field.
  function automatic int bpa_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bpa_tag_fifo.sv
// Synchronous tag FIFO remembering which requester owns each transfer in the stage chain.
// Asynchronous active-low reset empties it.
module bpa_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      // Simultaneous push and pop leave the occupancy unchanged.
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/booth_pipe_arbiter.sv
// Round-robin front end sharing one 4-phase Booth stage chain between NREQ requesters.
// Define BPA_SYNC_EN to put 2-flop synchronizers on pipe_ain/pipe_rout (self-timed chain).
module booth_pipe_arbiter
  import booth_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DW    = BOOTH_DW,
  parameter  int DEPTH = 4,
  localparam int IW    = bpa_id_w(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [IW-1:0]    rsp_id,
  output logic             pipe_rin,
  input  logic             pipe_ain,
  output logic [DW-1:0]    pipe_din,
  input  logic             pipe_rout,
  output logic             pipe_aout,
  input  logic [DW-1:0]    pipe_dout,
  output logic             err
);

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic          ain_s;
  logic          rout_s;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic          any_req;
  logic          grant;
  logic          capture;
  logic          fifo_full;
  logic          fifo_empty;
  logic [IW-1:0] fifo_head;

`ifdef BPA_SYNC_EN
  logic [1:0] ain_sync;
  logic [1:0] rout_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ain_sync  <= '0;
      rout_sync <= '0;
    end else begin
      ain_sync  <= {ain_sync[0], pipe_ain};
      rout_sync <= {rout_sync[0], pipe_rout};
    end
  end

  assign ain_s  = ain_sync[1];
  assign rout_s = rout_sync[1];
`else
  assign ain_s  = pipe_ain;
  assign rout_s = pipe_rout;
`endif

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && req_valid[IW'((int'(rr_ptr) + k) % NREQ)]) begin
        any_req = 1'b1;
        winner  = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign grant = reset && (in_state == I_IDLE) && any_req && !fifo_full;

  always_comb begin
    in_next   = in_state;
    req_ready = '0;
    pipe_rin  = 1'b0;
    case (in_state)
      I_IDLE: begin
        if (grant) begin
          req_ready = NREQ'(1) << winner;
          in_next   = I_RH;
        end
      end
      I_RH: begin
        pipe_rin = 1'b1;
        if (ain_s) in_next = I_RL;
      end
      I_RL: begin
        if (!ain_s) in_next = I_IDLE;
      end
      default: in_next = I_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_state <= I_IDLE;
      rr_ptr   <= '0;
      pipe_din <= '0;
    end else begin
      in_state <= in_next;
      if (grant) begin
        pipe_din <= req_data[winner*DW +: DW];
        rr_ptr   <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
      end
    end
  end

  bpa_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (winner),
    .pop       (capture),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign capture = (out_state == O_IDLE) && rout_s;

  always_comb begin
    out_next  = out_state;
    rsp_valid = 1'b0;
    pipe_aout = 1'b0;
    case (out_state)
      O_IDLE: begin
        if (rout_s) out_next = O_HOLD;
      end
      O_HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) out_next = O_ACK;
      end
      O_ACK: begin
        pipe_aout = 1'b1;
        if (!rout_s) out_next = O_IDLE;
      end
      default: out_next = O_IDLE;
    endcase
  end

  // A result with no outstanding tag is still delivered, as id 0, and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state <= O_IDLE;
      rsp_data  <= '0;
      rsp_id    <= '0;
      err       <= 1'b0;
    end else begin
      out_state <= out_next;
      if (capture) begin
        rsp_data <= pipe_dout;
        rsp_id   <= fifo_empty ? '0 : fifo_head;
        if (fifo_empty) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_pipe_arbiter.sv
// Directed bench for booth_pipe_arbiter with a behavioural 4-phase stage model that squares
// each operand; expected grants, ids and results are hand-computed constants.
module tb_booth_pipe_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
`ifdef BPA_SYNC_EN
  localparam int SYNC_S = 2;
`else
  localparam int SYNC_S = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic [IW-1:0]      rsp_id;
  logic               pipe_rin;
  logic               pipe_ain;
  logic [DW-1:0]      pipe_din;
  logic               pipe_rout;
  logic               pipe_aout;
  logic [DW-1:0]      pipe_dout;
  logic               err;

  always #5 clk = ~clk;

  booth_pipe_arbiter #(
    .NREQ  (NREQ),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .pipe_rin  (pipe_rin),
    .pipe_ain  (pipe_ain),
    .pipe_din  (pipe_din),
    .pipe_rout (pipe_rout),
    .pipe_aout (pipe_aout),
    .pipe_dout (pipe_dout),
    .err       (err)
  );

  int assert_count = 0;
  int fail_count   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Stage chain model: unbounded elastic pipeline whose result is operand squared.
  logic [63:0] res_q[$];
  bit          out_en  = 1'b1;
  int          ack_dly = 3;
  int          cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : stage_in
    logic [63:0] captured;
    pipe_ain = 1'b0;
    forever begin
      do begin @(posedge clk); #1; end while (pipe_rin !== 1'b1);
      captured = pipe_din;
      repeat (ack_dly) @(posedge clk);
      #1;
      pipe_ain = 1'b1;
      res_q.push_back(captured * captured);
      do begin @(posedge clk); #1; end while (pipe_rin !== 1'b0);
      pipe_ain = 1'b0;
    end
  end

  initial begin : stage_out
    pipe_rout = 1'b0;
    pipe_dout = '0;
    forever begin
      do begin @(posedge clk); #1; end while (!(out_en && res_q.size() > 0));
      pipe_dout = res_q[0];
      pipe_rout = 1'b1;
      do begin @(posedge clk); #1; end while (pipe_aout !== 1'b1);
      res_q.delete(0);
      pipe_rout = 1'b0;
      do begin @(posedge clk); #1; end while (pipe_aout !== 1'b0);
    end
  end

  // Observers sample mid-cycle, away from the rising edge.
  int          grant_q[$];
  int          rsp_id_q[$];
  logic [63:0] rsp_data_q[$];
  int          rout_rise_cyc = 0;
  int          rsp_rise_cyc  = 0;
  logic        rout_prev     = 1'b0;
  logic        valid_prev    = 1'b0;

  always @(negedge clk) begin
    if (req_ready != '0) begin
      checkOutput("req_ready_onehot", {63'b0, $onehot(req_ready)}, 64'd1);
      checkOutput("req_ready_in_handshake", {63'b0, pipe_rin}, 64'd0);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_q.push_back(i);
    end
    if (rsp_valid && rsp_ready) begin
      rsp_id_q.push_back(int'(rsp_id));
      rsp_data_q.push_back(rsp_data);
    end
    if (pipe_rout && !rout_prev) rout_rise_cyc = cyc;
    if (rsp_valid && !valid_prev) rsp_rise_cyc = cyc;
    rout_prev  = pipe_rout;
    valid_prev = rsp_valid;
  end

  function automatic logic [NREQ*DW-1:0] pack4(input logic [63:0] d3, input logic [63:0] d2,
                                               input logic [63:0] d1, input logic [63:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ*DW-1:0] data);
    @(posedge clk);
    #1;
    req_valid = valid;
    req_data  = data;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int t = 0;
    while (grant_q.size() < n && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
  endtask

  task automatic wait_rsps(input int n, input int budget);
    int t = 0;
    while (rsp_id_q.size() < n && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (!(res_q.size() == 0 && !pipe_rout && !pipe_aout && !rsp_valid && !pipe_rin && !pipe_ain)
           && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    checkOutput("idle_reached", {63'b0, (t < budget)}, 64'd1);
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_q.delete();
    rsp_id_q.delete();
    rsp_data_q.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int          rr_ids[5]  = '{0, 1, 2, 3, 0};
    logic [63:0] rr_dat[5]  = '{64'h10000, 64'h10201, 64'h10404, 64'h10609, 64'h10000};
    int          bp_ids[5]  = '{2, 3, 0, 1, 2};
    logic [63:0] bp_dat[5]  = '{64'h144, 64'h169, 64'h100, 64'h121, 64'h144};

    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    reset     = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_data", rsp_data, 64'd0);
    checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("rst_pipe_rin", 64'(pipe_rin), 64'd0);
    checkOutput("rst_pipe_din", pipe_din, 64'd0);
    checkOutput("rst_pipe_aout", 64'(pipe_aout), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    $display("[TB] round robin");
    clear_logs();
    applyStimulus(4'hF, pack4(64'h103, 64'h102, 64'h101, 64'h100));
    wait_grants(5, 300);
    applyStimulus(4'h0, '0);
    checkOutput("rr_grant_count", 64'(grant_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("rr_grant%0d", i), 64'(grant_q[i]), 64'(rr_ids[i]));
    wait_rsps(5, 400);
    checkOutput("rr_rsp_count", 64'(rsp_id_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_rsp_id%0d", i), 64'(rsp_id_q[i]), 64'(rr_ids[i]));
      checkOutput($sformatf("rr_rsp_data%0d", i), rsp_data_q[i], rr_dat[i]);
    end

    $display("[TB] single request");
    wait_idle(200);
    clear_logs();
    applyStimulus(4'b0100, pack4(64'h0, 64'h1234, 64'h0, 64'h0));
    wait_grants(1, 50);
    checkOutput("single_grant", 64'(grant_q[0]), 64'd2);
    applyStimulus(4'h0, '0);
    checkOutput("single_pipe_din", pipe_din, 64'h1234);
    checkOutput("single_rin_after_grant", 64'(pipe_rin), 64'd1);
    wait_rsps(1, 100);
    checkOutput("single_rsp_id", 64'(rsp_id_q[0]), 64'd2);
    checkOutput("single_rsp_data", rsp_data_q[0], 64'h14B5A90);
    checkOutput("single_rout_to_valid", 64'(rsp_rise_cyc - rout_rise_cyc), 64'(SYNC_S + 1));

    $display("[TB] reset mid-handshake");
    wait_idle(200);
    out_en = 1'b0;
    clear_logs();
    applyStimulus(4'b1000, pack4(64'h55, 64'h0, 64'h0, 64'h0));
    wait_grants(1, 50);
    applyStimulus(4'h0, '0);
    @(posedge clk); #1;
    checkOutput("midrst_in_rh", 64'(pipe_rin), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_pipe_rin", 64'(pipe_rin), 64'd0);
    checkOutput("midrst_pipe_din", pipe_din, 64'd0);
    checkOutput("midrst_rsp_data", rsp_data, 64'd0);
    checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_pipe_aout", 64'(pipe_aout), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    res_q.delete();
    reset  = 1'b1;
    out_en = 1'b1;
    clear_logs();
    applyStimulus(4'b0010, pack4(64'h0, 64'h0, 64'h2, 64'h0));
    wait_grants(1, 50);
    applyStimulus(4'h0, '0);
    wait_rsps(1, 100);
    checkOutput("postrst_rsp_id", 64'(rsp_id_q[0]), 64'd1);
    checkOutput("postrst_rsp_data", rsp_data_q[0], 64'd4);
    checkOutput("postrst_err", 64'(err), 64'd0);

    $display("[TB] back-pressure");
    wait_idle(200);
    out_en    = 1'b0;
    rsp_ready = 1'b0;
    clear_logs();
    applyStimulus(4'hF, pack4(64'h13, 64'h12, 64'h11, 64'h10));
    repeat (80) @(negedge clk);
    checkOutput("bp_grants_while_full", 64'(grant_q.size()), 64'd4);
    out_en = 1'b1;
    wait_grants(5, 100);
    applyStimulus(4'h0, '0);
    checkOutput("bp_grant_resumed", 64'(grant_q.size()), 64'd5);
    checkOutput("bp_fifth_grant", 64'(grant_q[4]), 64'd2);
    @(negedge clk);
    checkOutput("bp_rsp_held", 64'(rsp_valid), 64'd1);
    checkOutput("bp_rsp_id_held", 64'(rsp_id), 64'd2);
    repeat (5) @(negedge clk);
    checkOutput("bp_rsp_still_held", 64'(rsp_valid), 64'd1);
    checkOutput("bp_rsp_data_stable", rsp_data, 64'h144);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_rsps(5, 400);
    checkOutput("bp_rsp_count", 64'(rsp_id_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_rsp_id%0d", i), 64'(rsp_id_q[i]), 64'(bp_ids[i]));
      checkOutput($sformatf("bp_rsp_data%0d", i), rsp_data_q[i], bp_dat[i]);
    end

    $display("[TB] spurious pipe_rout");
    wait_idle(300);
    checkOutput("err_before_spurious", 64'(err), 64'd0);
    clear_logs();
    res_q.push_back(64'hABCD);
    wait_rsps(1, 50);
    checkOutput("spur_rsp_id", 64'(rsp_id_q[0]), 64'd0);
    checkOutput("spur_rsp_data", rsp_data_q[0], 64'hABCD);
    wait_idle(100);
    checkOutput("spur_err_set", 64'(err), 64'd1);
    checkOutput("spur_aout_low", 64'(pipe_aout), 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("spur_err_sticky", 64'(err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
